// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : univ_shift_reg
//  Purpose  : Parametrised universal shift register. It supports parallel
//             load, logical and arithmetic shifts, rotates and clear. Each
//             command uses a start/busy/done handshake, and multi-bit shifts
//             are sequenced as one bit per clock by an internal counter.
//  Revision : 1.0  initial release
// ============================================================================
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [2:0]       mode_i,
  input  logic [CNT_W-1:0] amount_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] data_o,
  output logic             ser_msb_o,
  output logic             ser_lsb_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [2:0] C_MODE_LOAD  = 3'b000;
  localparam logic [2:0] C_MODE_SLL   = 3'b001;
  localparam logic [2:0] C_MODE_SRL   = 3'b010;
  localparam logic [2:0] C_MODE_ROL   = 3'b011;
  localparam logic [2:0] C_MODE_ROR   = 3'b100;
  localparam logic [2:0] C_MODE_ASR   = 3'b101;
  localparam logic [2:0] C_MODE_CLEAR = 3'b110;

  localparam logic [CNT_W-1:0] C_MAX_AMT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [2:0]       r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;

  logic             w_load_type;
  logic [CNT_W-1:0] w_amt_clamped;
  logic [WIDTH-1:0] w_shifted;

  // One 1-bit step of the latched operation. Rotates and ASR do not use ser_i.
  function automatic logic [WIDTH-1:0] f_step(input logic [2:0]       mode,
                                               input logic [WIDTH-1:0] d,
                                               input logic             s);
    logic [WIDTH-1:0] res;
    res = d;
    case (mode)
      C_MODE_SLL: res = {d[WIDTH-2:0], s};
      C_MODE_SRL: res = {s, d[WIDTH-1:1]};
      C_MODE_ROL: res = {d[WIDTH-2:0], d[WIDTH-1]};
      C_MODE_ROR: res = {d[0], d[WIDTH-1:1]};
      C_MODE_ASR: res = {d[WIDTH-1], d[WIDTH-1:1]};
      default:    res = d;
    endcase
    return res;
  endfunction

  // Classify the incoming command and clamp its shift count to the width.
  always_comb begin
    w_load_type   = (mode_i == C_MODE_LOAD) || (mode_i == C_MODE_CLEAR) ||
                    (mode_i == 3'b111);
    w_amt_clamped = (amount_i > C_MAX_AMT) ? C_MAX_AMT : amount_i;
    w_shifted     = f_step(r_mode, r_data, ser_i);
  end

  // Control FSM and datapath register. A new command is accepted only in IDLE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_mode  <= 3'b000;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_mode <= mode_i;
            if (w_load_type) begin
              r_cnt <= '0;
              if (mode_i == C_MODE_LOAD) begin
                r_data <= data_i;
              end else if (mode_i == C_MODE_CLEAR) begin
                r_data <= '0;
              end
              r_state <= ST_DONE;
            end else if (w_amt_clamped == '0) begin
              r_cnt   <= '0;
              r_state <= ST_DONE;
            end else begin
              r_cnt   <= w_amt_clamped;
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_data <= w_shifted;
          r_cnt  <= r_cnt - C_ONE;
          if (r_cnt == C_ONE) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    data_o    = r_data;
    ser_msb_o = r_data[WIDTH-1];
    ser_lsb_o = r_data[0];
    busy_o    = (r_state != ST_IDLE);
    done_o    = (r_state == ST_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_univ_shift_reg
//  Purpose  : Directed self-checking bench for univ_shift_reg (WIDTH=8).
//             For each command the expected per-cycle outputs are queued, then
//             popped and compared against the DUT after every clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic             start_i;
  logic [2:0]       mode_i;
  logic [CNT_W-1:0] amount_i;
  logic [WIDTH-1:0] data_i;
  logic             ser_i;
  logic [WIDTH-1:0] data_o;
  logic             ser_msb_o;
  logic             ser_lsb_o;
  logic             busy_o;
  logic             done_o;

  int n_cmp = 0;
  int n_err = 0;

  // Expected observation: {data, busy, done}
  logic [WIDTH+1:0] sb_q[$];
  logic [WIDTH-1:0] model_q;

  univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   (start_i),
    .mode_i    (mode_i),
    .amount_i  (amount_i),
    .data_i    (data_i),
    .ser_i     (ser_i),
    .data_o    (data_o),
    .ser_msb_o (ser_msb_o),
    .ser_lsb_o (ser_lsb_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one single-bit operation on an 8-bit value.
  function automatic logic [7:0] ref_step(input logic [2:0] m, input logic [7:0] d,
                                          input logic s);
    logic [7:0] r;
    r = d;
    case (m)
      3'd1: r = (d << 1) | {7'd0, s};
      3'd2: r = (d >> 1) | {s, 7'd0};
      3'd3: r = (d << 1) | (d >> 7);
      3'd4: r = (d >> 1) | (d << 7);
      3'd5: r = (d >> 1) | (d & 8'h80);
      default: r = d;
    endcase
    return r;
  endfunction

  // Issue one command from IDLE and compare every following cycle against the
  // queued expectations. poke_idx >= 0 fires a competing start_i after that
  // observation, which the DUT must ignore.
  task automatic run_cmd(input string tag, input logic [2:0] m, input int amt,
                         input logic [7:0] din, input logic s, input int poke_idx);
    int   n;
    int   idx;
    logic [WIDTH+1:0] e;
    n = (amt > WIDTH) ? WIDTH : amt;
    if (m == 3'd0 || m == 3'd6 || m == 3'd7) begin
      if (m == 3'd0) model_q = din;
      if (m == 3'd6) model_q = 8'h00;
      sb_q.push_back({model_q, 2'b11});
    end else if (n == 0) begin
      sb_q.push_back({model_q, 2'b11});
    end else begin
      sb_q.push_back({model_q, 2'b10});
      for (int i = 1; i <= n; i++) begin
        model_q = ref_step(m, model_q, s);
        sb_q.push_back({model_q, 1'b1, (i == n)});
      end
    end
    sb_q.push_back({model_q, 2'b00});

    start_i  = 1'b1;
    mode_i   = m;
    amount_i = CNT_W'(amt);
    data_i   = din;
    ser_i    = s;
    @(posedge clk_i); #1;
    start_i  = 1'b0;
    mode_i   = 3'd6;
    amount_i = 4'd7;
    data_i   = 8'h3C;
    idx = 0;
    while (sb_q.size() > 0) begin
      if (idx > 0) begin
        @(posedge clk_i); #1;
      end
      e = sb_q.pop_front();
      check({tag, ".data"}, 32'(data_o), 32'(e[WIDTH+1:2]));
      check({tag, ".busy"}, 32'(busy_o), 32'(e[1]));
      check({tag, ".done"}, 32'(done_o), 32'(e[0]));
      check({tag, ".msb"},  32'(ser_msb_o), 32'(e[WIDTH+1]));
      check({tag, ".lsb"},  32'(ser_lsb_o), 32'(e[2]));
      if (idx == poke_idx) begin
        start_i = 1'b1;
        mode_i  = 3'd0;
        data_i  = 8'hFF;
      end else begin
        start_i = 1'b0;
      end
      idx++;
    end
  endtask

  initial begin
    rst_n_i  = 1'b0;
    start_i  = 1'b0;
    mode_i   = 3'd0;
    amount_i = '0;
    data_i   = '0;
    ser_i    = 1'b0;
    model_q  = 8'h00;
    #12;
    check("rst.data", 32'(data_o), 32'h00);
    check("rst.busy", 32'(busy_o), 32'h0);
    check("rst.done", 32'(done_o), 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Reset in the middle of an SLL-by-5 must clear without a clock edge.
    start_i  = 1'b1;
    mode_i   = 3'd1;
    amount_i = 4'd5;
    ser_i    = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    check("midrun.data", 32'(data_o), 32'h01);
    check("midrun.busy", 32'(busy_o), 32'h1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("arst.data", 32'(data_o), 32'h00);
    check("arst.busy", 32'(busy_o), 32'h0);
    check("arst.done", 32'(done_o), 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    check("arst.hold", 32'(busy_o), 32'h0);
    model_q = 8'h00;

    run_cmd("load_a5", 3'd0, 0, 8'hA5, 1'b0, -1);
    check("load_a5.val", 32'(data_o), 32'hA5);
    run_cmd("sll3", 3'd1, 3, 8'h00, 1'b1, 1);
    check("sll3.val", 32'(data_o), 32'h2F);
    run_cmd("load_a5b", 3'd0, 0, 8'hA5, 1'b0, -1);
    run_cmd("ror4", 3'd4, 4, 8'h00, 1'b1, -1);
    check("ror4.val", 32'(data_o), 32'h5A);
    run_cmd("ror12", 3'd4, 12, 8'h00, 1'b0, 3);
    check("ror12.val", 32'(data_o), 32'h5A);
    run_cmd("rol3", 3'd3, 3, 8'h00, 1'b0, -1);
    check("rol3.val", 32'(data_o), 32'hD2);
    run_cmd("load_96", 3'd0, 0, 8'h96, 1'b0, -1);
    run_cmd("asr2", 3'd5, 2, 8'h00, 1'b0, -1);
    check("asr2.val", 32'(data_o), 32'hE5);
    run_cmd("srl1", 3'd2, 1, 8'h00, 1'b0, -1);
    check("srl1.val", 32'(data_o), 32'h72);
    run_cmd("srl2s1", 3'd2, 2, 8'h00, 1'b1, -1);
    check("srl2s1.val", 32'(data_o), 32'hDC);
    run_cmd("sll0", 3'd1, 0, 8'h00, 1'b1, -1);
    check("sll0.val", 32'(data_o), 32'hDC);
    run_cmd("clear", 3'd6, 0, 8'hFF, 1'b0, -1);
    check("clear.val", 32'(data_o), 32'h00);
    run_cmd("load_3c", 3'd0, 0, 8'h3C, 1'b0, -1);
    run_cmd("rsvd", 3'd7, 0, 8'hFF, 1'b0, -1);
    check("rsvd.val", 32'(data_o), 32'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
